// File: rtl/fpnew_pkg.sv
// Shared FP types: status flags, formats and format widths.
// No ports; imported by the writeback path modules.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4,
    FP8ALT  = 3'd5
  } fp_format_e;

  // Unknown encodings report the full 64 bits, so they are never boxed.
  function automatic int unsigned fp_width(fp_format_e f);
    int unsigned w;
    case (f)
      FP32:    w = 32;
      FP64:    w = 64;
      FP16:    w = 16;
      FP16ALT: w = 16;
      FP8:     w = 8;
      FP8ALT:  w = 8;
      default: w = 64;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fpnew_nanbox_fmt.sv
// NaN-boxes a result to Width bits: bits at and above fp_width(fmt_i) forced to 1.
// Ports: result_i (raw), fmt_i (dst format), result_o (boxed); purely combinational.
module fpnew_nanbox_fmt
  import fpnew_pkg::*;
#(
  parameter int unsigned Width        = 64,
  parameter bit          EnableNanBox = 1'b1
) (
  input  logic [Width-1:0] result_i,
  input  fp_format_e       fmt_i,
  output logic [Width-1:0] result_o
);

  int unsigned w;

  always_comb begin
    w        = fp_width(fmt_i);
    result_o = result_i;
    if (EnableNanBox) begin
      for (int unsigned i = 0; i < Width; i++) begin
        if (i >= w) result_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpnew_sdotp_result_buffer.sv
// Elastic result queue behind the SDOTP/VSUM lane with NaN-boxing and sticky status.
// Ports: in_* push side, out_* pop side, flush_i, sticky_o/clr_sticky_i, busy_o.
module fpnew_sdotp_result_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned LaneWidth    = 64,
  parameter int unsigned Depth        = 2,
  parameter bit          EnableNanBox = 1'b1,
  parameter type         TagType      = logic,
  parameter type         AuxType      = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LaneWidth-1:0] in_result_i,
  input  status_t              in_status_i,
  input  logic                 in_ext_bit_i,
  input  fp_format_e           in_dst_fmt_i,
  input  TagType               in_tag_i,
  input  AuxType               in_aux_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [LaneWidth-1:0] out_result_o,
  output status_t              out_status_o,
  output logic                 out_ext_bit_o,
  output TagType               out_tag_o,
  output AuxType               out_aux_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output status_t              sticky_o,
  input  logic                 clr_sticky_i,
  output logic                 busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastP  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  typedef struct packed {
    logic [LaneWidth-1:0] result;
    status_t              status;
    logic                 ext_bit;
    fp_format_e           dst_fmt;
    TagType               tag;
    AuxType               aux;
  } entry_t;

  entry_t          mem_q [Depth];
  entry_t          head;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  status_t         sticky_q, sticky_d;
  logic            full, empty;
  logic            push, pop, we;

  // Modulo-Depth wrap; Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    logic [PtrW-1:0] n;
    n = (p == LastP) ? '0 : p + PtrW'(1);
    return n;
  endfunction

  assign full  = (cnt_q == DepthC);
  assign empty = (cnt_q == '0);

  // Ready depends only on state, never on out_ready_i.
  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign busy_o      = ~empty;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;
  assign we   = push & ~flush_i;

  assign head          = mem_q[rptr_q];
  assign out_status_o  = head.status;
  assign out_ext_bit_o = head.ext_bit;
  assign out_tag_o     = head.tag;
  assign out_aux_o     = head.aux;
  assign sticky_o      = sticky_q;

  fpnew_nanbox_fmt #(
    .Width        (LaneWidth),
    .EnableNanBox (EnableNanBox)
  ) i_nanbox (
    .result_i (head.result),
    .fmt_i    (head.dst_fmt),
    .result_o (out_result_o)
  );

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    // A pop discarded by flush does not reach the sticky flags.
    if (clr_sticky_i) begin
      sticky_d = (pop & ~flush_i) ? head.status : '0;
    end else if (pop & ~flush_i) begin
      sticky_d = sticky_q | head.status;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
    end else begin
      if (we) begin
        mem_q[wptr_q] <= '{
          result:  in_result_i,
          status:  in_status_i,
          ext_bit: in_ext_bit_i,
          dst_fmt: in_dst_fmt_i,
          tag:     in_tag_i,
          aux:     in_aux_i
        };
      end
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_fpnew_sdotp_result_buffer.sv
// Bench for fpnew_sdotp_result_buffer: Depth=2 and Depth=3 instances
// checked against a queue-based reference model.
module tb_fpnew_sdotp_result_buffer;
  import fpnew_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  st;
    logic        ext;
    logic [2:0]  fmt;
    logic [7:0]  tag;
    logic [3:0]  aux;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] a_res, b_res, a_ores, b_ores;
  logic [4:0]  a_st, b_st, a_ost, b_ost, a_stk, b_stk;
  logic        a_ext, b_ext, a_oext, b_oext;
  fp_format_e  a_fmt, b_fmt;
  logic [7:0]  a_tag, b_tag, a_otag, b_otag;
  logic [3:0]  a_aux, b_aux, a_oaux, b_oaux;
  logic        a_v, b_v, a_ir, b_ir, a_fl, b_fl;
  logic        a_ov, b_ov, a_rdy, b_rdy, a_clr, b_clr;
  logic        a_busy, b_busy;

  fpnew_sdotp_result_buffer #(
    .LaneWidth(64), .Depth(2), .EnableNanBox(1'b1),
    .TagType(logic [7:0]), .AuxType(logic [3:0])
  ) dut2 (
    .clk_i(clk), .rst_i(rst),
    .in_result_i(a_res), .in_status_i(a_st),
    .in_ext_bit_i(a_ext), .in_dst_fmt_i(a_fmt),
    .in_tag_i(a_tag), .in_aux_i(a_aux),
    .in_valid_i(a_v), .in_ready_o(a_ir),
    .flush_i(a_fl),
    .out_result_o(a_ores), .out_status_o(a_ost),
    .out_ext_bit_o(a_oext), .out_tag_o(a_otag),
    .out_aux_o(a_oaux), .out_valid_o(a_ov),
    .out_ready_i(a_rdy), .sticky_o(a_stk),
    .clr_sticky_i(a_clr), .busy_o(a_busy)
  );

  fpnew_sdotp_result_buffer #(
    .LaneWidth(64), .Depth(3), .EnableNanBox(1'b1),
    .TagType(logic [7:0]), .AuxType(logic [3:0])
  ) dut3 (
    .clk_i(clk), .rst_i(rst),
    .in_result_i(b_res), .in_status_i(b_st),
    .in_ext_bit_i(b_ext), .in_dst_fmt_i(b_fmt),
    .in_tag_i(b_tag), .in_aux_i(b_aux),
    .in_valid_i(b_v), .in_ready_o(b_ir),
    .flush_i(b_fl),
    .out_result_o(b_ores), .out_status_o(b_ost),
    .out_ext_bit_o(b_oext), .out_tag_o(b_otag),
    .out_aux_o(b_oaux), .out_valid_o(b_ov),
    .out_ready_i(b_rdy), .sticky_o(b_stk),
    .clr_sticky_i(b_clr), .busy_o(b_busy)
  );

  ent_t qa[$];
  ent_t qb[$];
  logic [4:0] sa = '0;
  logic [4:0] sb = '0;
  int nvec = 0;
  int nerr = 0;

  task automatic cmp(string t, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  function automatic int fpw(logic [2:0] f);
    case (f)
      3'd0:       return 32;
      3'd1:       return 64;
      3'd2, 3'd4: return 16;
      3'd3, 3'd5: return 8;
      default:    return 64;
    endcase
  endfunction

  function automatic logic [63:0] box(logic [63:0] r, logic [2:0] f);
    int w;
    logic [63:0] ones;
    w = fpw(f);
    ones = '1;
    if (w >= 64) return r;
    return r | (ones << w);
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.res = {$urandom, $urandom};
    e.st  = 5'($urandom);
    e.ext = 1'($urandom);
    e.fmt = 3'($urandom_range(0, 5));
    e.tag = 8'($urandom);
    e.aux = 4'($urandom);
    return e;
  endfunction

  task automatic set_a(ent_t e);
    a_res = e.res; a_st = e.st; a_ext = e.ext;
    a_fmt = fp_format_e'(e.fmt); a_tag = e.tag; a_aux = e.aux;
  endtask

  task automatic set_b(ent_t e);
    b_res = e.res; b_st = e.st; b_ext = e.ext;
    b_fmt = fp_format_e'(e.fmt); b_tag = e.tag; b_aux = e.aux;
  endtask

  task automatic chk();
    cmp("a_valid", a_ov, qa.size() != 0);
    cmp("a_ready", a_ir, qa.size() < 2);
    cmp("a_busy", a_busy, qa.size() != 0);
    cmp("a_sticky", a_stk, sa);
    if (qa.size() > 0) begin
      cmp("a_result", a_ores, box(qa[0].res, qa[0].fmt));
      cmp("a_status", a_ost, qa[0].st);
      cmp("a_ext", a_oext, qa[0].ext);
      cmp("a_tag", a_otag, qa[0].tag);
      cmp("a_aux", a_oaux, qa[0].aux);
    end
    cmp("b_valid", b_ov, qb.size() != 0);
    cmp("b_ready", b_ir, qb.size() < 3);
    cmp("b_busy", b_busy, qb.size() != 0);
    cmp("b_sticky", b_stk, sb);
    if (qb.size() > 0) begin
      cmp("b_result", b_ores, box(qb[0].res, qb[0].fmt));
      cmp("b_status", b_ost, qb[0].st);
      cmp("b_ext", b_oext, qb[0].ext);
      cmp("b_tag", b_otag, qb[0].tag);
      cmp("b_aux", b_oaux, qb[0].aux);
    end
  endtask

  // One clock: decide transfers from model occupancy, clock, update, check.
  task automatic tick();
    bit pa, oa, pb, ob;
    ent_t ea, eb, h;
    pa = a_v && qa.size() < 2;
    oa = a_rdy && qa.size() > 0;
    pb = b_v && qb.size() < 3;
    ob = b_rdy && qb.size() > 0;
    ea = '{a_res, a_st, a_ext, a_fmt, a_tag, a_aux};
    eb = '{b_res, b_st, b_ext, b_fmt, b_tag, b_aux};
    @(posedge clk);
    #1;
    if (a_fl) begin
      qa.delete();
      if (a_clr) sa = '0;
    end else begin
      if (oa) begin
        h = qa.pop_front();
        sa = a_clr ? h.st : (sa | h.st);
      end else if (a_clr) sa = '0;
      if (pa) qa.push_back(ea);
    end
    if (b_fl) begin
      qb.delete();
      if (b_clr) sb = '0;
    end else begin
      if (ob) begin
        h = qb.pop_front();
        sb = b_clr ? h.st : (sb | h.st);
      end else if (b_clr) sb = '0;
      if (pb) qb.push_back(eb);
    end
    chk();
  endtask

  task automatic idle();
    a_v = 0; a_rdy = 0; a_fl = 0; a_clr = 0;
    b_v = 0; b_rdy = 0; b_fl = 0; b_clr = 0;
  endtask

  initial begin
    ent_t e;
    idle();
    set_a('{64'd0, 5'd0, 1'b0, 3'd0, 8'd0, 4'd0});
    set_b('{64'd0, 5'd0, 1'b0, 3'd0, 8'd0, 4'd0});

    // Reset held for three cycles
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk();
    rst = 0;
    tick();

    // FP16 result is boxed, tag carried
    e = '{64'h0000_0000_0000_3C00, 5'd0, 1'b0, 3'd2, 8'd5, 4'd1};
    set_a(e);
    a_v = 1;
    tick();
    a_v = 0;
    cmp("t2_box", a_ores, 64'hFFFF_FFFF_FFFF_3C00);
    cmp("t2_tag", a_otag, 8'd5);
    a_rdy = 1;
    tick();
    a_rdy = 0;

    // Fill, then full with out_ready high blocks the push
    a_v = 1;
    repeat (2) begin
      set_a(rnd_ent());
      tick();
    end
    cmp("t3_full", a_ir, 1'b0);
    a_rdy = 1;
    set_a(rnd_ent());
    tick();
    cmp("t3_after_pop", a_ir, 1'b1);
    a_rdy = 0;
    tick();
    cmp("t3_push_next", a_ir, 1'b0);
    a_v = 0;
    a_rdy = 1;
    repeat (3) tick();
    idle();

    // Back-to-back streaming on both depths
    a_v = 1; a_rdy = 1; b_v = 1; b_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      set_a(rnd_ent());
      set_b(rnd_ent());
      tick();
    end
    a_v = 0; b_v = 0;
    repeat (4) tick();

    // Random traffic with occasional flush and clear
    for (int i = 0; i < 300; i++) begin
      set_a(rnd_ent());
      set_b(rnd_ent());
      a_v = 1'($urandom); a_rdy = 1'($urandom);
      b_v = 1'($urandom); b_rdy = 1'($urandom);
      a_clr = ($urandom_range(0, 7) == 0);
      b_clr = ($urandom_range(0, 7) == 0);
      a_fl = ($urandom_range(0, 15) == 0);
      b_fl = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    a_rdy = 1; b_rdy = 1;
    repeat (4) tick();
    idle();

    // Sticky accumulation and clear-with-pop
    a_clr = 1;
    tick();
    a_clr = 0;
    e = rnd_ent(); e.st = 5'b00001; set_a(e);
    a_v = 1;
    tick();
    e = rnd_ent(); e.st = 5'b10000; set_a(e);
    tick();
    a_v = 0;
    a_rdy = 1;
    repeat (2) tick();
    cmp("t5_sticky_or", a_stk, 5'b10001);
    a_rdy = 0;
    e = rnd_ent(); e.st = 5'b00100; set_a(e);
    a_v = 1;
    tick();
    a_v = 0;
    a_rdy = 1; a_clr = 1;
    tick();
    cmp("t5_clr_pop", a_stk, 5'b00100);
    idle();

    // Flush discards queue and the same-cycle push
    a_v = 1;
    repeat (2) begin
      set_a(rnd_ent());
      tick();
    end
    a_fl = 1;
    a_rdy = 1;
    set_a(rnd_ent());
    tick();
    cmp("t6_flush_valid", a_ov, 1'b0);
    cmp("t6_flush_busy", a_busy, 1'b0);
    idle();
    tick();
    cmp("t6_flush_kept_sticky", a_stk, 5'b00100);

    // Asynchronous reset in the middle of a cycle
    a_v = 1; b_v = 1;
    repeat (2) begin
      set_a(rnd_ent());
      set_b(rnd_ent());
      tick();
    end
    #2;
    rst = 1;
    #1;
    cmp("t6_rst_a_valid", a_ov, 1'b0);
    cmp("t6_rst_a_busy", a_busy, 1'b0);
    cmp("t6_rst_a_ready", a_ir, 1'b1);
    cmp("t6_rst_a_sticky", a_stk, 5'd0);
    cmp("t6_rst_b_valid", b_ov, 1'b0);
    cmp("t6_rst_b_ready", b_ir, 1'b1);
    qa.delete(); qb.delete();
    sa = '0; sb = '0;
    idle();
    @(posedge clk);
    #1;
    rst = 0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
